// File: rtl/cpc_io_pkg.sv
// Shared definitions for CPC I/O-bus responders.
// Holds the printer-port decode constants and the printer BUSY FSM encoding.
// No ports; imported by cpc_printer_port.
package cpc_io_pkg;

  // A12 low selects the printer port (&EFxx) under the CPC's partial decode.
  localparam int PRN_ADDR_BIT = 12;

  // Bit 7 of the latched port value drives the Centronics STROBE line.
  localparam int STROBE_BIT = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    FULL = 2'd2
  } prn_state_e;

endpackage

// File: rtl/cpc_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with register-array storage.
// Ports:
//   clk, reset (async, active-high), clear (sync flush)
//   wr_en/wr_data : write request; ignored when full unless a read happens
//                   in the same cycle
//   rd_en/rd_data : rd_data always shows the head entry; rd_en pops it
//   count         : occupancy 0..DEPTH
//   full, empty   : occupancy flags
module cpc_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             do_wr;
  logic             do_rd;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem[rd_ptr];

  // A write into a full FIFO is still legal when the head leaves this cycle.
  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);

  // Pointers are power-of-two wide, so they wrap by plain overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/cpc_printer_port.sv
// CPC Centronics printer-port responder.
// Latches CPU OUT writes to &EFxx, turns each 0->1 edge of the latched STROBE
// bit into one 7-bit byte pushed into a capture FIFO, and drives printer BUSY.
// Ports:
//   clk, reset (async, active-high)
//   cpu_addr, io_dout, io_wr : CPU I/O write bus (io_wr is a multi-cycle level)
//   busy                     : printer BUSY, routed to PPI port B bit 6
//   out_valid/out_data/out_ready : FWFT consumer interface, out_data[7]=0
//   fifo_count               : FIFO occupancy
//   overflow                 : sticky, a strobe was dropped on a full FIFO
//   clear                    : synchronous flush of FIFO, overflow and FSM
module cpc_printer_port
  import cpc_io_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int BUSY_MIN   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  io_dout,
  input  logic        io_wr,
  output logic        busy,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready,
  output logic [8:0]  fifo_count,
  output logic        overflow,
  input  logic        clear
);

  localparam int HOLD_W = (BUSY_MIN > 1) ? $clog2(BUSY_MIN) : 1;
  localparam int CW     = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]        port_reg;
  logic              io_wr_d;
  logic              strobe_d;
  logic              sel;
  logic              strobe_rise;
  logic              pop;
  logic              accept;
  logic              drop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_cnt;
  logic [HOLD_W-1:0] hold;
  logic [HOLD_W-1:0] hold_next;
  prn_state_e        state;
  prn_state_e        state_next;
  logic              unused_addr;

  // Only A12 takes part in the decode; the rest of the bus is don't-care.
  assign unused_addr = ^{cpu_addr[15:13], cpu_addr[11:0]};

  // First clk of an io_wr level only, so a long OUT latches once.
  assign sel = io_wr & ~io_wr_d & ~cpu_addr[PRN_ADDR_BIT];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      io_wr_d  <= 1'b0;
      port_reg <= 8'h00;
      strobe_d <= 1'b0;
    end else begin
      io_wr_d  <= io_wr;
      strobe_d <= port_reg[STROBE_BIT];
      if (sel) begin
        port_reg <= io_dout;
      end
    end
  end

  // Edge of the latched STROBE bit; holding bit 7 high never re-triggers.
  assign strobe_rise = port_reg[STROBE_BIT] & ~strobe_d;
  assign pop         = out_valid & out_ready;
  assign accept      = strobe_rise & (~fifo_full | pop) & ~clear;
  assign drop        = strobe_rise & fifo_full & ~pop & ~clear;

  cpc_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .wr_en   (accept),
    .wr_data ({1'b0, port_reg[6:0]}),
    .rd_en   (pop),
    .rd_data (out_data),
    .count   (fifo_cnt),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign out_valid  = ~fifo_empty;
  assign fifo_count = 9'(fifo_cnt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (clear) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

  // BUSY FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      hold  <= '0;
    end else begin
      state <= state_next;
      hold  <= hold_next;
    end
  end

  // BUSY FSM: next state. Any accepted push (re)starts the ACK hold window.
  always_comb begin
    state_next = state;
    hold_next  = hold;
    if (clear) begin
      state_next = IDLE;
      hold_next  = '0;
    end else if (accept) begin
      state_next = ACK;
      hold_next  = HOLD_W'(BUSY_MIN - 1);
    end else begin
      case (state)
        ACK: begin
          if (hold == '0) begin
            state_next = fifo_full ? FULL : IDLE;
          end else begin
            hold_next = hold - 1'b1;
          end
        end
        FULL: begin
          if (!fifo_full) begin
            state_next = IDLE;
          end
        end
        default: state_next = state;
      endcase
    end
  end

  // BUSY FSM: outputs
  always_comb begin
    busy = 1'b1;
    if (state == IDLE) begin
      busy = fifo_full;
    end
  end

endmodule
